// File: rtl/vga_pkg.sv
// Shared encodings for the VGA test-pattern generator: FSM states, pattern
// modes and the eight-colour RGB565 bar table.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRE_WRITE = 2'd1,
    ST_WRITING   = 2'd2,
    ST_COMPLETE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_RAMP    = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [15:0] BAR_RGB565 [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/vga_pattern_pix.sv
// Pure combinational pixel evaluator: maps (mode, seed, x, y) to one pixel
// value. The parent registers the result.
module vga_pattern_pix
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int DATA_W   = 16,
  parameter int CHK_LOG2 = 5,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [DATA_W-1:0] pix_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic       x_bit;
  logic       y_bit;

  // NOTE: every variable written here is assigned first, so no path infers a latch.
  always_comb begin
    bar_idx = 3'(x_i / X_W'(BAR_W));
    x_bit   = 1'(x_i >> CHK_LOG2);
    y_bit   = 1'(y_i >> CHK_LOG2);
    pix_o   = '0;
    case (mode_e'(mode_i))
      // Truncation to DATA_W is the mod 2^DATA_W wrap of the linear index.
      MODE_RAMP:    pix_o = seed_i + DATA_W'(y_i) * DATA_W'(H_ACTIVE) + DATA_W'(x_i);
      MODE_BARS:    pix_o = DATA_W'(BAR_RGB565[bar_idx]);
      MODE_CHECKER: pix_o = (x_bit ^ y_bit) ? '1 : '0;
      MODE_SOLID:   pix_o = seed_i;
      default:      pix_o = '0;
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Frame-based test-pattern source: one start edge produces one frame of
// H_ACTIVE x V_ACTIVE pixels, paced by wr_en, with registered outputs.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int DATA_W   = 16,
  parameter int SPAN_NUM = 1,
  parameter int CHK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  input  logic              wr_en,
  output logic              data_en,
  output logic [DATA_W-1:0] dout,
  output logic              sof_o,
  output logic              eol_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int X_W = $clog2(H_ACTIVE);
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [2:0]        sync_q, sync_d;
  logic [1:0]        vld_q, vld_d;
  logic              armed_q, armed_d;
  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              data_en_q, data_en_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              start_pulse;
  logic              accept;
  logic [DATA_W-1:0] pix;

  vga_pattern_pix #(
    .H_ACTIVE (H_ACTIVE),
    .DATA_W   (DATA_W),
    .CHK_LOG2 (CHK_LOG2),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_pix (
    .mode_i (mode_q),
    .seed_i (seed_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .pix_o  (pix)
  );

  always_comb begin
    start_pulse = sync_q[1] & ~sync_q[2];
    accept      = (state_q == ST_WRITING) & wr_en & ~abort_i;

    sync_d      = {sync_q[1:0], start_i};
    // The reset zeros in the chain are not real samples; a start level held
    // across reset release must be seen low once before an edge counts.
    vld_d       = {vld_q[0], 1'b1};
    armed_d     = armed_q | (vld_q[1] & ~sync_q[1]);

    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    frame_cnt_d = frame_cnt_q;

    data_en_d   = accept;
    dout_d      = accept ? pix : dout_q;
    sof_d       = accept & (x_q == '0) & (y_q == '0);
    eol_d       = accept & (x_q == X_LAST);

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse && armed_q) state_d = ST_PRE_WRITE;
        end
        ST_PRE_WRITE: begin
          x_d     = '0;
          y_d     = '0;
          mode_d  = mode_e'(mode_i);
          state_d = ST_WRITING;
        end
        ST_WRITING: begin
          if (accept) begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
              if (y_q == Y_LAST) begin
                state_d     = ST_COMPLETE;
                seed_d      = seed_q + DATA_W'(SPAN_NUM);
                frame_cnt_d = frame_cnt_q + 16'd1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        ST_COMPLETE: state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_COMPLETE);
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      vld_q       <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= MODE_RAMP;
      seed_q      <= '0;
      data_en_q   <= 1'b0;
      dout_q      <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync_q      <= sync_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      data_en_q   <= data_en_d;
      dout_q      <= dout_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign data_en     = data_en_q;
  assign dout        = dout_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: three differently-sized instances
// driven by directed and randomised frames, compared against a pixel model.
module tb_vga_pattern_gen;

  localparam int H_CFG    [3] = '{8, 16, 8};
  localparam int V_CFG    [3] = '{2, 2, 4};
  localparam int CHK_CFG  [3] = '{1, 5, 1};
  localparam int SPAN_CFG [3] = '{3, 1, 1};
  localparam logic [15:0] BAR_REF [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [3];
  logic        abort_v [3];
  logic        wr_v    [3];
  logic [1:0]  mode_v  [3];
  logic        den_v   [3];
  logic        sof_v   [3];
  logic        eol_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] dout_v  [3];
  logic [15:0] fcnt_v  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vga_pattern_gen #(
      .H_ACTIVE (H_CFG[g]),
      .V_ACTIVE (V_CFG[g]),
      .DATA_W   (16),
      .SPAN_NUM (SPAN_CFG[g]),
      .CHK_LOG2 (CHK_CFG[g])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_v[g]),
      .abort_i     (abort_v[g]),
      .mode_i      (mode_v[g]),
      .wr_en       (wr_v[g]),
      .data_en     (den_v[g]),
      .dout        (dout_v[g]),
      .sof_o       (sof_v[g]),
      .eol_o       (eol_v[g]),
      .busy_o      (busy_v[g]),
      .done_o      (done_v[g]),
      .frame_cnt_o (fcnt_v[g])
    );
  end

  int          n_pass = 0;
  int          n_total = 0;
  int          cur = 0;
  int          done_cnt = 0;
  int          exp_seed [3];
  int          exp_fcnt [3];
  logic [17:0] pq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: advance past the edge, then record the selected instance.
  task automatic step();
    @(posedge clk);
    #1;
    if (den_v[cur]) pq.push_back({sof_v[cur], eol_v[cur], dout_v[cur]});
    if (done_v[cur]) done_cnt++;
  endtask

  // Pixel number idx of a frame, straight from the pattern definitions.
  function automatic logic [15:0] ref_pix(int sel, int mode, int seed, int idx);
    int h = H_CFG[sel];
    int x = idx % h;
    int y = idx / h;
    int c = CHK_CFG[sel];
    case (mode)
      0:       return 16'((seed + y * h + x) % 65536);
      1:       return BAR_REF[x / (h / 8)];
      2:       return ((((x >> c) ^ (y >> c)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return 16'(seed);
    endcase
  endfunction

  // style: 0 wr_en high, 1 wr_en toggling, 2 random wr_en/start/mode noise.
  task automatic do_frame(input int sel, input int mode, input int style,
                          input int abort_at, input string tag);
    int h, n, k, first, post, exp_len;
    bit aborted;
    h = H_CFG[sel];
    n = h * V_CFG[sel];
    cur = sel;
    start_v[sel] = 1'b0;
    abort_v[sel] = 1'b0;
    mode_v[sel]  = 2'(mode);
    wr_v[sel]    = 1'b1;
    repeat (3) step();
    pq.delete();
    done_cnt = 0;
    start_v[sel] = 1'b1;
    k = 0; first = 0; post = 0; aborted = 1'b0;
    while (done_cnt == 0 && k < 600 && post < 8) begin
      step();
      k++;
      if (den_v[sel] && first == 0) first = k;
      if (aborted) post++;
      abort_v[sel] = 1'b0;
      if (abort_at >= 0 && !aborted && pq.size() == abort_at) begin
        abort_v[sel] = 1'b1;
        aborted = 1'b1;
      end
      case (style)
        0:       wr_v[sel] = 1'b1;
        1:       wr_v[sel] = ~wr_v[sel];
        default: wr_v[sel] = 1'($urandom_range(0, 1));
      endcase
      if (style == 2 && k >= 3 && pq.size() > 0 && pq.size() < n / 2)
        start_v[sel] = 1'($urandom_range(0, 1));
      else if (k >= 3)
        start_v[sel] = 1'b0;
      if (style == 2 && pq.size() > 0) mode_v[sel] = 2'($urandom_range(0, 3));
    end

    exp_len = (abort_at >= 0) ? abort_at : n;
    check($sformatf("%s_len", tag), pq.size(), exp_len);
    if (style == 0) check($sformatf("%s_first_edge", tag), first, 5);
    for (int i = 0; i < pq.size() && i < exp_len; i++)
      check($sformatf("%s_px%0d", tag, i), pq[i],
            {(i == 0), (i % h == h - 1), ref_pix(sel, mode, exp_seed[sel], i)});
    if (abort_at < 0) begin
      exp_seed[sel] = (exp_seed[sel] + SPAN_CFG[sel]) % 65536;
      exp_fcnt[sel] = (exp_fcnt[sel] + 1) % 65536;
    end

    start_v[sel] = 1'b0;
    abort_v[sel] = 1'b0;
    repeat (6) step();
    check($sformatf("%s_done_cycles", tag), done_cnt, (abort_at < 0) ? 1 : 0);
    check($sformatf("%s_busy_after", tag), busy_v[sel], 0);
    check($sformatf("%s_frame_cnt", tag), fcnt_v[sel], exp_fcnt[sel]);
    check($sformatf("%s_no_extra_px", tag), pq.size(), exp_len);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; wr_v[i] = 1'b0; mode_v[i] = 2'd0;
      exp_seed[i] = 0;   exp_fcnt[i] = 0;
    end
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_flags%0d", i),
            {den_v[i], sof_v[i], eol_v[i], busy_v[i], done_v[i]}, 0);
      check($sformatf("reset_dout_fcnt%0d", i), {dout_v[i], fcnt_v[i]}, 0);
    end
    rst_n = 1'b1;
    repeat (3) step();

    do_frame(0, 0, 0, -1, "ramp1");
    do_frame(0, 0, 0, -1, "ramp2");
    do_frame(1, 1, 1, -1, "bars_toggle");
    do_frame(2, 2, 0, -1, "checker");
    do_frame(0, 0, 0, 5,  "abort");
    do_frame(0, 0, 0, -1, "after_abort");
    do_frame(1, 3, 0, -1, "solid");
    for (int r = 0; r < 6; r++)
      do_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2, -1,
               $sformatf("rand%0d", r));

    // Reset in the middle of a frame, with start_i held high through release.
    cur = 0;
    start_v[0] = 1'b0; mode_v[0] = 2'd0; wr_v[0] = 1'b1;
    repeat (3) step();
    pq.delete();
    start_v[0] = 1'b1;
    for (int k = 0; k < 20 && pq.size() < 3; k++) step();
    check("rst_frame_running", pq.size() >= 3, 1);
    rst_n = 1'b0;
    #2;
    check("rst_async_flags", {den_v[0], sof_v[0], eol_v[0], busy_v[0], done_v[0]}, 0);
    check("rst_async_dout_fcnt", {dout_v[0], fcnt_v[0]}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_seed[i] = 0;
      exp_fcnt[i] = 0;
    end
    pq.delete();
    done_cnt = 0;
    step();
    check("rst_first_cycle_den", den_v[0], 0);
    repeat (10) step();
    check("rst_held_start_px", pq.size(), 0);
    check("rst_held_start_busy", busy_v[0], 0);
    do_frame(0, 0, 0, -1, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
